cpu_trace_buffer: RTL and testbench

- Parametrised, synthesizable execution-trace capture unit for the single-cycle MIPS CPU.
- Records per-instruction retire information into a circular buffer: pc, instruction word, write-back data, and the RegWrite/MemWrite flags.
- Supports a programmable trigger with pre- and post-trigger windows, then drains the capture through a valid/ready readout port.
- Sits beside the cpu core; it can be used in simulation benches or on-chip as a debug probe.

---
 rtl/cpu_trace_buffer.sv | 162 ++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - circular retire-trace capture with trigger window and valid/ready readout
// Optional TRACE_TIMESTAMP_EN prepends a TS_W-bit cycle stamp to every entry.
module cpu_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int TS_W      = 16,
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W  = 3*DATA_W+2+TS_W,
`else
  localparam int ENTRY_W  = 3*DATA_W+2,
`endif
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic [1:0]         trig_mode,
  input  logic [DATA_W-1:0]  trig_pc,
  input  logic               cap_valid,
  input  logic [DATA_W-1:0]  cap_pc,
  input  logic [DATA_W-1:0]  cap_instr,
  input  logic [DATA_W-1:0]  cap_wb_data,
  input  logic               cap_reg_write,
  input  logic               cap_mem_write,
  output logic [1:0]         state,
  output logic               triggered,
  output logic               overflow,
  output logic [AW:0]        fill_count,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_data
);

  if (DEPTH < 4 || (DEPTH & (DEPTH-1)) != 0 || POST_TRIG < 1 || POST_TRIG > DEPTH || TS_W < 1)
  begin : g_param_check
    $error("cpu_trace_buffer: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, PRETRIG = 2'd1, POSTTRIG = 2'd2, DONE = 2'd3} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t             state_q;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        post_cnt;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] wr_entry;
  logic               capturing;
  logic               wr_en;
  logic               full;
  logic               trig_hit;
  logic [AW-1:0]      wr_ptr_inc;
  logic [AW:0]        fill_inc;

  assign capturing  = (state_q == PRETRIG) || (state_q == POSTTRIG);
  assign wr_en      = !rst && capturing && cap_valid;
  assign full       = (fill_count == FULL);
  assign wr_ptr_inc = wr_ptr + 1'b1;
  assign fill_inc   = full ? fill_count : fill_count + 1'b1;

  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode)
      2'd0: trig_hit = (cap_pc == trig_pc);
      2'd1: trig_hit = cap_mem_write;
      2'd2: trig_hit = cap_reg_write;
      2'd3: trig_hit = 1'b1;
      default: trig_hit = 1'b0;
    endcase
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk) begin
    if (rst)
      ts <= '0;
    else if (state_q == IDLE && arm)
      ts <= '0;
    else if (capturing)
      ts <= ts + 1'b1;
  end

  assign wr_entry = {ts, cap_mem_write, cap_reg_write, cap_wb_data, cap_instr, cap_pc};
`else
  assign wr_entry = {cap_mem_write, cap_reg_write, cap_wb_data, cap_instr, cap_pc};
`endif

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      post_cnt   <= '0;
      triggered  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_q    <= PRETRIG;
            wr_ptr     <= '0;
            fill_count <= '0;
            triggered  <= 1'b0;
            overflow   <= 1'b0;
          end
        end
        PRETRIG, POSTTRIG: begin
          if (cap_valid) begin
            wr_ptr     <= wr_ptr_inc;
            fill_count <= fill_inc;
            if (full)
              overflow <= 1'b1;
            // On the final write, rd_ptr lands on the oldest surviving entry
            if (state_q == PRETRIG) begin
              if (trig_hit) begin
                triggered <= 1'b1;
                if (POST_TRIG == 1) begin
                  state_q <= DONE;
                  rd_ptr  <= wr_ptr_inc - fill_inc[AW-1:0];
                end else begin
                  state_q  <= POSTTRIG;
                  post_cnt <= (AW+1)'(POST_TRIG-1);
                end
              end
            end else begin
              post_cnt <= post_cnt - 1'b1;
              if (post_cnt == 1) begin
                state_q <= DONE;
                rd_ptr  <= wr_ptr_inc - fill_inc[AW-1:0];
              end
            end
          end
        end
        DONE: begin
          if (fill_count == 0) begin
            state_q <= IDLE;
          end else if (rd_ready) begin
            rd_ptr     <= rd_ptr + 1'b1;
            fill_count <= fill_count - 1'b1;
            if (fill_count == 1)
              state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state    = state_q;
  assign rd_valid = (state_q == DONE) && (fill_count != 0);
  assign rd_data  = mem[rd_ptr];

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - directed bench for cpu_trace_buffer (DEPTH=8, POST_TRIG=3)
module tb_cpu_trace_buffer;

  localparam int DW = 32;
  localparam int EW = 3*DW+2;

  logic          clk = 0;
  logic          rst = 1;
  logic          arm = 0;
  logic [1:0]    trig_mode = 0;
  logic [DW-1:0] trig_pc = 0;
  logic          cap_valid = 0;
  logic [DW-1:0] cap_pc = 0;
  logic [DW-1:0] cap_instr = 0;
  logic [DW-1:0] cap_wb_data = 0;
  logic          cap_reg_write = 0;
  logic          cap_mem_write = 0;
  logic [1:0]    state;
  logic          triggered;
  logic          overflow;
  logic [3:0]    fill_count;
  logic          rd_valid;
  logic          rd_ready = 0;
  logic [EW-1:0] rd_data;

  int checks = 0;
  int fails  = 0;

  cpu_trace_buffer #(.DATA_W(DW), .DEPTH(8), .POST_TRIG(3), .TS_W(16)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_mode(trig_mode), .trig_pc(trig_pc),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr), .cap_wb_data(cap_wb_data),
    .cap_reg_write(cap_reg_write), .cap_mem_write(cap_mem_write),
    .state(state), .triggered(triggered), .overflow(overflow), .fill_count(fill_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_entry(input logic v, input logic [31:0] pc, input logic rw, input logic mw);
    cap_valid     = v;
    cap_pc        = pc;
    cap_instr     = {16'hABCD, pc[15:0]};
    cap_wb_data   = ~pc;
    cap_reg_write = rw;
    cap_mem_write = mw;
  endtask

  task automatic check_status(input string name, input logic [1:0] st, input logic [3:0] fc,
                              input logic tr, input logic ov);
    checks++;
    if (state !== st || fill_count !== fc || triggered !== tr || overflow !== ov) begin
      fails++;
      $display("FAIL %s: state=%0d fill=%0d trig=%0b ovf=%0b, expected state=%0d fill=%0d trig=%0b ovf=%0b",
               name, state, fill_count, triggered, overflow, st, fc, tr, ov);
    end
  endtask

  task automatic arm_capture(input logic [1:0] mode, input logic [31:0] tpc);
    trig_mode = mode;
    trig_pc   = tpc;
    arm       = 1;
    drive_entry(1, 32'hFC, 1, 1);
    step();
    arm = 0;
    drive_entry(0, 0, 0, 0);
  endtask

  // Readout of n entries whose pcs run first_pc, +4, ...; mw_idx marks the one mem_write entry
  task automatic drain(input string name, input logic [31:0] first_pc, input int n,
                       input bit bp, input int mw_idx, input int rw_idx);
    int idx = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [EW-1:0] held = '0;
    logic [31:0] epc;
    while (idx < n && cyc < 200) begin
      rd_ready = bp ? (cyc % 3 == 0) : 1'b1;
      epc = first_pc + 32'(4*idx);
      checks++;
      if (rd_valid !== 1'b1 || rd_data[31:0] !== epc || rd_data[63:32] !== {16'hABCD, epc[15:0]}
          || rd_data[95:64] !== ~epc || rd_data[97] !== (idx == mw_idx)
          || rd_data[96] !== (idx == rw_idx)) begin
        fails++;
        $display("FAIL %s entry %0d: valid=%0b pc=%h instr=%h flags=%b, expected valid=1 pc=%h mw=%0b rw=%0b",
                 name, idx, rd_valid, rd_data[31:0], rd_data[63:32], rd_data[97:96], epc,
                 idx == mw_idx, idx == rw_idx);
      end
      if (stalled) begin
        checks++;
        if (rd_data !== held) begin
          fails++;
          $display("FAIL %s stall-stable: rd_data=%h, expected %h", name, rd_data, held);
        end
      end
      if (rd_ready) begin
        idx++;
        stalled = 0;
      end else begin
        held = rd_data;
        stalled = 1;
      end
      step();
      cyc++;
    end
    rd_ready = 0;
    checks++;
    if (idx != n) begin
      fails++;
      $display("FAIL %s drain-timeout: delivered=%0d, expected %0d", name, idx, n);
    end
    checks++;
    if (rd_valid !== 1'b0 || state !== 2'd0 || fill_count !== 4'd0) begin
      fails++;
      $display("FAIL %s post-drain: valid=%0b state=%0d fill=%0d, expected valid=0 state=0 fill=0",
               name, rd_valid, state, fill_count);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    step();
    check_status("reset", 2'd0, 4'd0, 0, 0);
    checks++;
    if (rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset rd_valid: got %0b, expected 0", rd_valid);
    end
    rst = 0;
    drive_entry(1, 32'h40, 1, 1);
    step();
    check_status("idle-ignores-cap", 2'd0, 4'd0, 0, 0);
    drive_entry(0, 0, 0, 0);
  endtask

  task automatic test_mode0_nowrap();
    arm_capture(2'd0, 32'h10);
    check_status("mode0-armed", 2'd1, 4'd0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drive_entry(1, 32'(4*i), 0, 0);
      step();
      if (i == 4) check_status("mode0-trigger", 2'd2, 4'd5, 1, 0);
    end
    drive_entry(0, 0, 0, 0);
    check_status("mode0-done", 2'd3, 4'd7, 1, 0);
    drain("mode0-read", 32'h0, 7, 0, -1, -1);
    check_status("mode0-sticky", 2'd0, 4'd0, 1, 0);
  endtask

  task automatic test_wrap();
    arm_capture(2'd0, 32'h30);
    for (int i = 0; i < 15; i++) begin
      drive_entry(1, 32'(4*i), 0, 0);
      step();
      if (i == 7) check_status("wrap-full", 2'd1, 4'd8, 0, 0);
      if (i == 8) check_status("wrap-first-overwrite", 2'd1, 4'd8, 0, 1);
    end
    drive_entry(0, 0, 0, 0);
    check_status("wrap-done", 2'd3, 4'd8, 1, 1);
    drain("wrap-read", 32'h1C, 8, 0, -1, -1);
  endtask

  task automatic test_mode1_gaps();
    logic pattern [9] = '{1, 0, 1, 1, 0, 1, 1, 0, 1};
    int vcount = 0;
    arm_capture(2'd1, 32'h104);
    for (int i = 0; i < 9; i++) begin
      if (pattern[i]) begin
        drive_entry(1, 32'h100 + 32'(4*vcount), vcount == 1, vcount == 3);
        vcount++;
      end else begin
        drive_entry(0, 32'hDEAD, 1, 1);
      end
      step();
      if (i == 5) check_status("mode1-trigger", 2'd2, 4'd4, 1, 0);
      if (i == 7) check_status("mode1-gap-hold", 2'd2, 4'd5, 1, 0);
    end
    drive_entry(1, 32'h200, 0, 1);
    step();
    drive_entry(0, 0, 0, 0);
    check_status("mode1-done-nowrite", 2'd3, 4'd6, 1, 0);
    drain("mode1-read", 32'h100, 6, 0, 3, 1);
  endtask

  task automatic test_backpressure();
    arm_capture(2'd2, 32'h0);
    for (int i = 0; i < 6; i++) begin
      drive_entry(1, 32'h500 + 32'(4*i), i == 2, 0);
      step();
    end
    drive_entry(0, 0, 0, 0);
    check_status("bp-done", 2'd3, 4'd5, 1, 0);
    drain("bp-read", 32'h500, 5, 1, -1, 2);
  endtask

  task automatic test_reset_posttrig();
    arm_capture(2'd3, 32'h0);
    drive_entry(1, 32'h600, 0, 0);
    step();
    check_status("imm-trigger", 2'd2, 4'd1, 1, 0);
    drive_entry(1, 32'h604, 0, 0);
    rst = 1;
    step();
    rst = 0;
    drive_entry(0, 0, 0, 0);
    check_status("reset-posttrig", 2'd0, 4'd0, 0, 0);
    checks++;
    if (rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset-posttrig rd_valid: got %0b, expected 0", rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_mode0_nowrap();
    test_wrap();
    test_mode1_gaps();
    test_backpressure();
    test_reset_posttrig();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
